// File: rtl/life_gen_sched_if.sv
// Row-RAM port shared between the generation sequencer and the dual-bank board RAM.
// The sequencer drives as master; the RAM/arbiter side is the slave.
interface life_gen_sched_if #(
    parameter int COLS = 40,
    parameter int AW   = 5
);
    logic            mem_req;
    logic            mem_gnt;
    logic            rd_en;
    logic [AW-1:0]   rd_addr;
    logic [COLS-1:0] rd_data;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [COLS-1:0] wr_data;
    logic            rd_bank;

    modport master (
        output mem_req, rd_en, rd_addr, wr_en, wr_addr, wr_data, rd_bank,
        input  mem_gnt, rd_data
    );

    modport slave (
        input  mem_req, rd_en, rd_addr, wr_en, wr_addr, wr_data, rd_bank,
        output mem_gnt, rd_data
    );
endinterface

// File: rtl/life_gen_sched.sv
// Runs one Game-of-Life generation: streams source rows through an above/cur/below
// window, writes each next-state row to the opposite bank, then flips banks.
module life_gen_sched #(
    parameter int COLS = 40,
    parameter int ROWS = 30,
    parameter int AW   = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    life_gen_sched_if.master mem,
    output logic             busy,
    output logic             done,
    output logic [15:0]      gen_count
);

    typedef enum logic [2:0] {IDLE, RD, CAP, WR, SWAP} state_t;

    localparam logic [AW-1:0] LAST = AW'(ROWS);

    state_t          state_q;
    logic [AW-1:0]   p_q;
    logic [COLS-1:0] above_q, cur_q, below_q;
    logic            rd_bank_q;
    logic            done_q;
    logic [15:0]     gen_q;

    logic            in_grid;
    logic [COLS-1:0] wr_row_d;
    logic [COLS+1:0] a_pad, c_pad, b_pad;
    logic [3:0]      cnt;

    assign in_grid = (p_q < LAST);

    // Zero padding on both ends models the dead cells beyond the left/right edges.
    assign a_pad = {1'b0, above_q, 1'b0};
    assign c_pad = {1'b0, cur_q,   1'b0};
    assign b_pad = {1'b0, below_q, 1'b0};

    always_comb begin
        wr_row_d = '0;
        cnt      = '0;
        for (int j = 0; j < COLS; j++) begin
            cnt = {3'b0, a_pad[j]} + {3'b0, a_pad[j+1]} + {3'b0, a_pad[j+2]}
                + {3'b0, c_pad[j]}                      + {3'b0, c_pad[j+2]}
                + {3'b0, b_pad[j]} + {3'b0, b_pad[j+1]} + {3'b0, b_pad[j+2]};
            wr_row_d[j] = (cnt == 4'd3) || (cur_q[j] && (cnt == 4'd2));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            p_q       <= '0;
            above_q   <= '0;
            cur_q     <= '0;
            below_q   <= '0;
            rd_bank_q <= 1'b0;
            done_q    <= 1'b0;
            gen_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (start) begin
                    above_q <= '0;
                    cur_q   <= '0;
                    below_q <= '0;
                    p_q     <= '0;
                    state_q <= RD;
                end
                RD: if (!in_grid || mem.mem_gnt) state_q <= CAP;
                CAP: begin
                    above_q <= cur_q;
                    cur_q   <= below_q;
                    below_q <= in_grid ? mem.rd_data : '0;
                    // Row 0 only primes the window; nothing to write yet.
                    if (p_q != '0) begin
                        state_q <= WR;
                    end else begin
                        p_q     <= p_q + AW'(1);
                        state_q <= RD;
                    end
                end
                WR: if (mem.mem_gnt) begin
                    if (p_q == LAST) begin
                        state_q <= SWAP;
                    end else begin
                        p_q     <= p_q + AW'(1);
                        state_q <= RD;
                    end
                end
                SWAP: begin
                    rd_bank_q <= ~rd_bank_q;
                    gen_q     <= gen_q + 16'd1;
                    done_q    <= 1'b1;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Strobes follow the grant combinationally so a granted cycle is never wasted.
    assign mem.mem_req = ((state_q == RD) && in_grid) || (state_q == WR);
    assign mem.rd_en   = (state_q == RD) && in_grid && mem.mem_gnt;
    assign mem.rd_addr = p_q;
    assign mem.wr_en   = (state_q == WR) && mem.mem_gnt;
    assign mem.wr_addr = p_q - AW'(1);
    assign mem.wr_data = wr_row_d;
    assign mem.rd_bank = rd_bank_q;

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign gen_count = gen_q;

endmodule

// File: tb/tb_life_gen_sched.sv
// Directed bench for life_gen_sched: dual-bank row RAM model plus hand-computed boards.
module tb_life_gen_sched;

    localparam int COLS = 40;
    localparam int ROWS = 30;
    localparam int AW   = 5;
    localparam logic [COLS-1:0] JUNK = 40'hA5A5A5A5A5;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        busy;
    logic        done;
    logic [15:0] gen_count;

    life_gen_sched_if #(.COLS(COLS), .AW(AW)) mif ();

    life_gen_sched #(.COLS(COLS), .ROWS(ROWS), .AW(AW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .mem       (mif),
        .busy      (busy),
        .done      (done),
        .gen_count (gen_count)
    );

    logic [COLS-1:0] bank  [2][ROWS];
    logic [COLS-1:0] exp_b [ROWS];
    int n_chk  = 0;
    int n_pass = 0;
    int viol   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    // RAM model: writes land in the non-display bank; read data appears the cycle after rd_en.
    initial begin
        logic       pend;
        logic       pbank;
        logic [AW-1:0] paddr;
        pend = 1'b0;
        pbank = 1'b0;
        paddr = '0;
        mif.rd_data = '0;
        forever begin
            @(negedge clk);
            if (mif.rd_en && mif.wr_en) viol++;
            if (!mif.mem_gnt && (mif.rd_en || mif.wr_en)) viol++;
            if (mif.wr_en) begin
                if (mif.wr_addr >= AW'(ROWS)) viol++;
                else bank[mif.rd_bank ? 0 : 1][mif.wr_addr] = mif.wr_data;
            end
            if (mif.rd_en && mif.rd_addr >= AW'(ROWS)) viol++;
            pend  = mif.rd_en && (mif.rd_addr < AW'(ROWS));
            pbank = mif.rd_bank;
            paddr = mif.rd_addr;
            @(posedge clk);
            #1;
            mif.rd_data = pend ? bank[pbank][paddr] : 40'hDEADBEEF00;
        end
    end

    task automatic fill(input int b, input logic [COLS-1:0] v);
        for (int r = 0; r < ROWS; r++) bank[b][r] = v;
    endtask

    task automatic exp_clear();
        for (int r = 0; r < ROWS; r++) exp_b[r] = '0;
    endtask

    task automatic chk_bank(input int b, input string tag);
        for (int r = 0; r < ROWS; r++)
            chk($sformatf("%s_row%0d", tag, r), {24'b0, bank[b][r]}, {24'b0, exp_b[r]});
    endtask

    // Called #1 after a clock edge; that edge's successor samples start (cycle 0).
    task automatic run_gen(input bit tog, input bit pulses, output int lat, output int nd);
        lat = -1;
        nd  = 0;
        start = 1'b1;
        mif.mem_gnt = 1'b1;
        @(posedge clk);
        #1;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            mif.mem_gnt = tog ? cyc[0] : 1'b1;
            start = pulses && (cyc == 10 || cyc == 50 || cyc == 93);
            if (done) begin
                nd++;
                if (lat < 0) lat = cyc;
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        mif.mem_gnt = 1'b1;
    endtask

    initial begin
        int lat;
        int nd;
        int last;
        reset_n = 1'b0;
        start = 1'b0;
        mif.mem_gnt = 1'b1;
        fill(0, '0);
        fill(1, JUNK);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",    {63'b0, busy},        64'd0);
        chk("rst_done",    {63'b0, done},        64'd0);
        chk("rst_req",     {63'b0, mif.mem_req}, 64'd0);
        chk("rst_rd_en",   {63'b0, mif.rd_en},   64'd0);
        chk("rst_wr_en",   {63'b0, mif.wr_en},   64'd0);
        chk("rst_bank",    {63'b0, mif.rd_bank}, 64'd0);
        chk("rst_gen",     {48'b0, gen_count},   64'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Blinker: horizontal triple on row 14 turns vertical over rows 13..15.
        bank[0][14] = 40'h00001C0000;
        run_gen(1'b0, 1'b0, lat, nd);
        exp_clear();
        exp_b[13] = 40'h0000080000;
        exp_b[14] = 40'h0000080000;
        exp_b[15] = 40'h0000080000;
        chk_bank(1, "blink");
        chk("blink_lat",  lat, 94);
        chk("blink_nd",   nd, 1);
        chk("blink_bank", {63'b0, mif.rd_bank}, 64'd1);
        chk("blink_gen",  {48'b0, gen_count}, 64'd1);
        chk("blink_busy", {63'b0, busy}, 64'd0);

        // Reset during the WR that targets row 10 (p=11, cycle 35).
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (34) @(posedge clk);
        #1;
        chk("mid_wr_en",   {63'b0, mif.wr_en}, 64'd1);
        chk("mid_wr_addr", {59'b0, mif.wr_addr}, 64'd10);
        reset_n = 1'b0;
        #1;
        chk("mrst_busy",  {63'b0, busy},        64'd0);
        chk("mrst_req",   {63'b0, mif.mem_req}, 64'd0);
        chk("mrst_wr_en", {63'b0, mif.wr_en},   64'd0);
        chk("mrst_rd_en", {63'b0, mif.rd_en},   64'd0);
        chk("mrst_bank",  {63'b0, mif.rd_bank}, 64'd0);
        chk("mrst_gen",   {48'b0, gen_count},   64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        fill(1, JUNK);
        run_gen(1'b0, 1'b0, lat, nd);
        chk_bank(1, "rerun");
        chk("rerun_lat",  lat, 94);
        chk("rerun_bank", {63'b0, mif.rd_bank}, 64'd1);
        chk("rerun_gen",  {48'b0, gen_count}, 64'd1);

        // All-ones board: only the four corners survive, no wrap-around.
        fill(1, {COLS{1'b1}});
        fill(0, JUNK);
        run_gen(1'b0, 1'b0, lat, nd);
        exp_clear();
        exp_b[0]  = 40'h8000000001;
        exp_b[29] = 40'h8000000001;
        chk_bank(0, "ones");
        chk("ones_bank", {63'b0, mif.rd_bank}, 64'd0);
        chk("ones_gen",  {48'b0, gen_count}, 64'd2);

        // Grant alternates 1,0,...: 29 stalled RD/WR cycles push done from 94 to 123.
        fill(0, '0);
        bank[0][14] = 40'h00001C0000;
        fill(1, JUNK);
        run_gen(1'b1, 1'b0, lat, nd);
        exp_clear();
        exp_b[13] = 40'h0000080000;
        exp_b[14] = 40'h0000080000;
        exp_b[15] = 40'h0000080000;
        chk_bank(1, "tog");
        chk("tog_lat",  lat, 123);
        chk("tog_nd",   nd, 1);
        chk("tog_bank", {63'b0, mif.rd_bank}, 64'd1);
        chk("tog_gen",  {48'b0, gen_count}, 64'd3);

        // start pulses while busy (including in SWAP) must be ignored.
        fill(0, JUNK);
        run_gen(1'b0, 1'b1, lat, nd);
        exp_clear();
        exp_b[14] = 40'h00001C0000;
        chk_bank(0, "pulse");
        chk("pulse_lat",  lat, 94);
        chk("pulse_nd",   nd, 1);
        chk("pulse_gen",  {48'b0, gen_count}, 64'd4);
        chk("pulse_bank", {63'b0, mif.rd_bank}, 64'd0);

        // Glider, four back-to-back generations with start held high.
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        fill(0, '0);
        bank[0][0] = 40'h4000000000;
        bank[0][1] = 40'h2000000000;
        bank[0][2] = 40'hE000000000;
        fill(1, JUNK);
        nd = 0;
        last = -1;
        start = 1'b1;
        @(posedge clk);
        #1;
        for (int cyc = 1; cyc <= 450; cyc++) begin
            if (cyc == 283) start = 1'b0;
            if (done) begin
                nd++;
                last = cyc;
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        exp_clear();
        exp_b[1] = 40'h2000000000;
        exp_b[2] = 40'h1000000000;
        exp_b[3] = 40'h7000000000;
        chk_bank(0, "glider");
        chk("glider_nd",   nd, 4);
        chk("glider_last", last, 376);
        chk("glider_gen",  {48'b0, gen_count}, 64'd4);
        chk("glider_bank", {63'b0, mif.rd_bank}, 64'd0);

        chk("strobe_viol", viol, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
